// File: rtl/uart_pkg.sv
// Shared constants, state encoding and parity helper for the UART transmitter.
// UART_TX_STOP2_EN selects two stop bits (12-bit frame) instead of one.
package uart_pkg;

  localparam int unsigned CLK_HZ       = 3125000;
  localparam int unsigned BAUD         = 115200;
  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

`ifdef UART_TX_STOP2_EN
  localparam int unsigned STOP_BITS    = 2;
`else
  localparam int unsigned STOP_BITS    = 1;
`endif
  localparam int unsigned FRAME_BITS   = 1 + DATA_BITS + 1 + STOP_BITS;

  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable modulo-CLKS_PER_BIT counter; bit_end is high during the last
// cycle of each bit period and is held low while restart is asserted.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic clk_3125,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  logic [CNT_W-1:0] count;

  // bit_end is registered one count early so it lines up with the final count
  always_ff @(posedge clk_3125) begin
    if (rst || restart) begin
      count   <= '0;
      bit_end <= 1'b0;
    end else begin
      if (count == CNT_W'(CLKS_PER_BIT - 1)) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
      bit_end <= (count == CNT_W'(CLKS_PER_BIT - 2));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB-first, even parity, stop.
// Define UART_TX_STOP2_EN for two stop bits.
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   shift, shift_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic                   parity, parity_nxt;
  logic                   tx_nxt, busy_nxt, done_nxt;
  logic                   bit_end;
  logic                   timer_restart;

  // Timer is held at zero while idle so each frame starts on a fresh bit period
  assign timer_restart = (state == ST_IDLE);

  uart_bit_timer u_bit_timer (
    .clk_3125 (clk_3125),
    .rst      (rst),
    .restart  (timer_restart),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      idx      <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      idx      <= idx_nxt;
      parity   <= parity_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
      tx_ready <= ~busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift;
    idx_nxt    = idx;
    parity_nxt = parity;
    tx_nxt     = tx;
    busy_nxt   = tx_busy;
    done_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tx_start && tx_ready) begin
          shift_nxt  = tx_data;
          parity_nxt = even_parity(tx_data);
          tx_nxt     = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_nxt    = shift[DATA_BITS-1];
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        // Line always shows shift[7]; the next bit is pre-fetched from shift[6]
        if (bit_end) begin
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            idx_nxt   = '0;
            tx_nxt    = parity;
            state_nxt = ST_PARITY;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            tx_nxt    = shift[DATA_BITS-2];
            shift_nxt = {shift[DATA_BITS-2:0], 1'b0};
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tx_nxt    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
`ifdef UART_TX_STOP2_EN
          if (idx == '0) begin
            idx_nxt = IDX_W'(1);
          end else begin
            idx_nxt   = '0;
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
`else
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of bytes with hand-computed frames plus
// sequences for busy-ignore, back-to-back and mid-frame reset.
module tb_uart_tx;

  localparam int CPB = 27;
`ifdef UART_TX_STOP2_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif
  localparam int FRAME_CYC = NB * CPB;

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  junk;
    logic [10:0] frame;
    logic        par;
  } vec_t;

  logic       clk_3125 = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_3125 = ~clk_3125;

  uart_tx dut (
    .clk_3125 (clk_3125),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_3125);
    #1;
  endtask

  // Raise tx_start once ready; returns one step after the accepting edge
  task automatic start_req(input logic [7:0] d);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 1000) begin
      tick();
      w++;
    end
    check("start_wait_ready", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
  endtask

  // Observe one frame from the accepting edge (c=0) through the tx_done cycle
  task automatic run_frame(input string name, input logic [7:0] d, input logic [10:0] f11,
                           input logic par, input logic [7:0] junk, input bit drop,
                           input bit inject);
    logic [NB-1:0] samp;
    logic [NB-1:0] expf;
    logic [7:0]    rxb;
    int            dcnt;
    int            dat;
    bit            rb_ok;
    bit            rdy_low;
    samp    = '0;
    dcnt    = 0;
    dat     = -1;
    rb_ok   = 1'b1;
    rdy_low = 1'b1;
`ifdef UART_TX_STOP2_EN
    expf = {f11, 1'b1};
`else
    expf = f11;
`endif
    check({name, ".start_edge"}, 32'(tx), 32'd0);
    for (int c = 0; c <= FRAME_CYC; c++) begin
      if (c == 0 && drop) tx_start = 1'b0;
      if (c == 1) tx_data = junk;
      if (inject && c == 50) begin
        tx_start = 1'b1;
        tx_data  = 8'h55;
      end
      if (inject && c == 51) tx_start = 1'b0;
      if (c % CPB == CPB / 2 && c < FRAME_CYC) samp = {samp[NB-2:0], tx};
      if (tx_done === 1'b1) begin
        dcnt++;
        dat = c;
      end
      if (tx_ready === tx_busy) rb_ok = 1'b0;
      if (c < FRAME_CYC && tx_ready !== 1'b0) rdy_low = 1'b0;
      if (c < FRAME_CYC) tick();
    end
    rxb = samp[NB-2 -: 8];
    check({name, ".frame"},     32'(samp),      32'(expf));
    check({name, ".rx_byte"},   32'(rxb),       32'(d));
    check({name, ".rx_parity"}, 32'(samp[NB-10]), 32'(par));
    check({name, ".done_cnt"},  32'(dcnt),      32'd1);
    check({name, ".done_at"},   32'(dat),       32'(FRAME_CYC));
    check({name, ".ready_nbusy"}, 32'(rb_ok),   32'd1);
    check({name, ".ready_low"}, 32'(rdy_low),   32'd1);
    check({name, ".end_tx"},    32'(tx),        32'd1);
    check({name, ".end_ready"}, 32'(tx_ready),  32'd1);
  endtask

  initial begin
    vec_t vecs[4];
    bit   ok;

    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    vecs[0] = '{data: 8'hCA, junk: 8'h11, frame: 11'h329, par: 1'b0};
    vecs[1] = '{data: 8'h3B, junk: 8'hC4, frame: 11'h0EF, par: 1'b1};
    vecs[2] = '{data: 8'h00, junk: 8'hFF, frame: 11'h001, par: 1'b0};
    vecs[3] = '{data: 8'hFF, junk: 8'h00, frame: 11'h3FD, par: 1'b0};

    repeat (3) tick();
    check("rst.tx",    32'(tx),       32'd1);
    check("rst.ready", 32'(tx_ready), 32'd1);
    check("rst.busy",  32'(tx_busy),  32'd0);
    check("rst.done",  32'(tx_done),  32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      start_req(vecs[i].data);
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].frame, vecs[i].par,
                vecs[i].junk, 1'b1, 1'b0);
      tick();
      check($sformatf("vec%0d.done_width", i), 32'(tx_done), 32'd0);
      repeat (3) tick();
    end

    // Request while busy must not be queued
    start_req(8'hA5);
    run_frame("busy", 8'hA5, 11'h295, 1'b0, 8'h3C, 1'b1, 1'b1);
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
    end
    check("busy.no_queue", 32'(ok), 32'd1);

    // Back-to-back with tx_start held high
    start_req(8'h81);
    run_frame("b2b0", 8'h81, 11'h205, 1'b0, 8'h7E, 1'b0, 1'b0);
    tick();
    run_frame("b2b1", 8'h7E, 11'h1F9, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();

    // Reset at cycle 100 of a frame
    start_req(8'hA5);
    tx_start = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    check("midrst.tx",    32'(tx),       32'd1);
    check("midrst.busy",  32'(tx_busy),  32'd0);
    check("midrst.ready", 32'(tx_ready), 32'd1);
    check("midrst.done",  32'(tx_done),  32'd0);
    rst = 1'b0;
    ok  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (tx !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
    end
    check("midrst.quiet", 32'(ok), 32'd1);
    start_req(8'hCA);
    run_frame("post_rst", 8'hCA, 11'h329, 1'b0, 8'h99, 1'b1, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
